wb_pipe_stage: RTL and testbench

Parametrised writeback stage for the five-stage core: it replaces the combinational writeback mux with a registered MEM/WB boundary. It selects the result source (memory, link PC, execute, CSR) and applies load sign/zero extension. The result is held in a 2-entry skid buffer under a valid/ready handshake. The block drives the register-file write port, the forwarding bus and the commit interface, and optionally counts retired instructions.

---
 rtl/wb_pipe_stage_pkg.sv | 33 +++
 rtl/wb_skid_buf.sv | 52 +++++
 rtl/wb_pipe_stage.sv | 113 +++++++++++
 tb/tb_wb_pipe_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pipe_stage_pkg.sv
// Shared writeback definitions: source-select bit positions, load-size codes
// and the load extension helper used by wb_pipe_stage.
package wb_pipe_stage_pkg;

    localparam int WB_SEL_MEM = 0;
    localparam int WB_SEL_PC  = 1;
    localparam int WB_SEL_EXE = 2;
    localparam int WB_SEL_CSR = 3;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    // Operates at 64 bits; narrower datapaths truncate the result.
    function automatic logic [63:0] ld_extend(
        input logic [63:0] d,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [63:0] r;
        r = d;
        case (size)
            LD_B: r = uns ? {56'b0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
            LD_H: r = uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            LD_W: r = uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            LD_D: r = d;
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Generic 2-entry valid/ready FIFO used as the MEM/WB boundary register.
// Owns the occupancy count; outputs read 0 while empty or in reset.
module wb_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // Ready comes from registered state only, never from out_ready.
    assign in_ready  = !rst && (count < 2'd2);
    assign out_valid = !rst && (count != 2'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// Registered writeback stage: source mux, load extension, skid buffer.
// Optional retire counter enabled by defining WB_INSTRET_EN.
module wb_pipe_stage
    import wb_pipe_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int PC_INC = 4,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_sel,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_wen,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_exe_data,
    input  logic [XLEN-1:0]   in_mem_data,
    input  logic [XLEN-1:0]   in_csr_data,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    output logic              cmt_valid,
    input  logic              cmt_ready,
    output logic [XLEN-1:0]   cmt_pc,
    output logic [XLEN-1:0]   cmt_wdata,
    output logic [REG_AW-1:0] cmt_rd,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic [CNT_W-1:0]  instret
);

    localparam int PW = 2 * XLEN + REG_AW + 1;

    logic [1:0]        eff_size;
    logic [63:0]       mem_ext64;
    logic [XLEN-1:0]   mem_ext;
    logic [XLEN-1:0]   link_pc;
    logic [XLEN-1:0]   wdata;
    logic [PW-1:0]     in_pl;
    logic [PW-1:0]     head;
    logic [XLEN-1:0]   h_pc;
    logic [XLEN-1:0]   h_wdata;
    logic [REG_AW-1:0] h_rd;
    logic              h_wen;
    logic              commit;
    logic              writes;

    // A 32-bit core has no doubleword loads; treat them as word loads.
    assign eff_size  = (XLEN == 32 && in_ld_size == LD_D) ? LD_W : in_ld_size;
    assign mem_ext64 = ld_extend(64'(in_mem_data), eff_size, in_ld_unsigned);
    assign mem_ext   = mem_ext64[XLEN-1:0];
    assign link_pc   = in_pc + XLEN'(PC_INC);

    assign wdata = ({XLEN{in_sel[WB_SEL_MEM]}} & mem_ext)
                 | ({XLEN{in_sel[WB_SEL_PC]}}  & link_pc)
                 | ({XLEN{in_sel[WB_SEL_EXE]}} & in_exe_data)
                 | ({XLEN{in_sel[WB_SEL_CSR]}} & in_csr_data);

    assign in_pl = {in_pc, wdata, in_rd, in_rd_wen};

    wb_skid_buf #(
        .W(PW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_pl),
        .out_valid(cmt_valid),
        .out_ready(cmt_ready),
        .out_data (head)
    );

    assign {h_pc, h_wdata, h_rd, h_wen} = head;

    assign commit = cmt_valid && cmt_ready;
    assign writes = h_wen && (h_rd != '0);

    assign cmt_pc    = h_pc;
    assign cmt_wdata = h_wdata;
    assign cmt_rd    = h_rd;

    assign rf_wen   = commit && writes;
    assign rf_waddr = h_rd;
    assign rf_wdata = h_wdata;

    assign fwd_valid = cmt_valid && writes;
    assign fwd_rd    = h_rd;
    assign fwd_data  = h_wdata;

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (commit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign instret = cnt;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed self-checking bench for wb_pipe_stage (XLEN=64, CNT_W=4).
// Honours WB_INSTRET_EN for the expected retire count.
module tb_wb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_sel;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [63:0] in_pc;
    logic [63:0] in_exe_data;
    logic [63:0] in_mem_data;
    logic [63:0] in_csr_data;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic        cmt_valid;
    logic        cmt_ready;
    logic [63:0] cmt_pc;
    logic [63:0] cmt_wdata;
    logic [4:0]  cmt_rd;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [3:0]  instret;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    wb_pipe_stage #(
        .XLEN  (64),
        .REG_AW(5),
        .PC_INC(4),
        .CNT_W (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sel        (in_sel),
        .in_rd         (in_rd),
        .in_rd_wen     (in_rd_wen),
        .in_pc         (in_pc),
        .in_exe_data   (in_exe_data),
        .in_mem_data   (in_mem_data),
        .in_csr_data   (in_csr_data),
        .in_ld_size    (in_ld_size),
        .in_ld_unsigned(in_ld_unsigned),
        .cmt_valid     (cmt_valid),
        .cmt_ready     (cmt_ready),
        .cmt_pc        (cmt_pc),
        .cmt_wdata     (cmt_wdata),
        .cmt_rd        (cmt_rd),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .instret       (instret)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [63:0] pc,
                         input logic [4:0] rd, input logic wen,
                         input logic [63:0] mem, input logic [63:0] exe,
                         input logic [63:0] csr, input logic [1:0] sz,
                         input logic uns);
        in_valid       = 1'b1;
        in_sel         = sel;
        in_pc          = pc;
        in_rd          = rd;
        in_rd_wen      = wen;
        in_mem_data    = mem;
        in_exe_data    = exe;
        in_csr_data    = csr;
        in_ld_size     = sz;
        in_ld_unsigned = uns;
    endtask

    initial begin
        logic [3:0] exp_cnt;
`ifdef WB_INSTRET_EN
        exp_cnt = 4'd1;
`else
        exp_cnt = 4'd0;
`endif
        rst = 1'b1;
        cmt_ready = 1'b0;
        drive(4'b0000, 64'h0, 5'd0, 1'b0, 64'h0, 64'h0, 64'h0, 2'd0, 1'b0);
        in_valid = 1'b0;
        step();
        step();
        chk("rst_cmt_valid", 64'(cmt_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_rf_wen", 64'(rf_wen), 64'd0);
        chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("rst_instret", 64'(instret), 64'd0);
        chk("rst_wdata", cmt_wdata, 64'd0);

        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        cmt_ready = 1'b1;
        drive(4'b0001, 64'h100, 5'd5, 1'b1, 64'h80F0, 64'h0, 64'h0, 2'd0, 1'b0);
        step();
        chk("lb_signed", rf_wdata, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("lb_rf_wen", 64'(rf_wen), 64'd1);
        chk("lb_waddr", 64'(rf_waddr), 64'd5);
        chk("lb_pc", cmt_pc, 64'h100);

        drive(4'b0001, 64'h104, 5'd5, 1'b1, 64'h80F0, 64'h0, 64'h0, 2'd1, 1'b0);
        step();
        chk("lh_signed", rf_wdata, 64'hFFFF_FFFF_FFFF_80F0);

        drive(4'b0001, 64'h108, 5'd5, 1'b1, 64'h80F0, 64'h0, 64'h0, 2'd1, 1'b1);
        step();
        chk("lhu", rf_wdata, 64'h0000_0000_0000_80F0);

        drive(4'b0001, 64'h10C, 5'd6, 1'b1, 64'h8000_0001, 64'h0, 64'h0, 2'd2, 1'b0);
        step();
        chk("lw_signed", rf_wdata, 64'hFFFF_FFFF_8000_0001);

        drive(4'b0001, 64'h110, 5'd6, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h0, 2'd3, 1'b0);
        step();
        chk("ld", rf_wdata, 64'h1234_5678_9ABC_DEF0);

        drive(4'b0010, 64'h8000_0000, 5'd1, 1'b1, 64'h0, 64'h0, 64'h0, 2'd0, 1'b0);
        step();
        chk("link_data", rf_wdata, 64'h8000_0004);
        chk("link_wen", 64'(rf_wen), 64'd1);

        drive(4'b0010, 64'h8000_0000, 5'd0, 1'b1, 64'h0, 64'h0, 64'h0, 2'd0, 1'b0);
        step();
        chk("x0_wen", 64'(rf_wen), 64'd0);
        chk("x0_cmt_valid", 64'(cmt_valid), 64'd1);
        chk("x0_fwd", 64'(fwd_valid), 64'd0);

        drive(4'b0100, 64'h120, 5'd7, 1'b1, 64'h0, 64'hA5, 64'h3C, 2'd0, 1'b0);
        step();
        chk("exe_sel", rf_wdata, 64'hA5);

        drive(4'b1000, 64'h124, 5'd7, 1'b1, 64'h0, 64'hA5, 64'h3C, 2'd0, 1'b0);
        step();
        chk("csr_sel", rf_wdata, 64'h3C);

        drive(4'b0000, 64'h128, 5'd7, 1'b1, 64'hFF, 64'hA5, 64'h3C, 2'd3, 1'b0);
        step();
        chk("no_sel", rf_wdata, 64'h0);

        drive(4'b0101, 64'h12C, 5'd7, 1'b1, 64'hF0, 64'h0F, 64'h3C, 2'd3, 1'b0);
        step();
        chk("multi_hot", rf_wdata, 64'hFF);

        drive(4'b0100, 64'h130, 5'd3, 1'b0, 64'h0, 64'h55, 64'h0, 2'd0, 1'b0);
        step();
        chk("nowen_rf", 64'(rf_wen), 64'd0);
        chk("nowen_fwd", 64'(fwd_valid), 64'd0);

        in_valid = 1'b0;
        step();
        chk("drain_empty", 64'(cmt_valid), 64'd0);

        cmt_ready = 1'b0;
        drive(4'b0100, 64'h200, 5'd1, 1'b1, 64'h0, 64'h11, 64'h0, 2'd0, 1'b0);
        step();
        chk("bp_ready1", 64'(in_ready), 64'd1);
        chk("bp_fwd", 64'(fwd_valid), 64'd1);
        chk("bp_fwd_data", fwd_data, 64'h11);
        chk("bp_no_wen", 64'(rf_wen), 64'd0);
        drive(4'b0100, 64'h204, 5'd2, 1'b1, 64'h0, 64'h22, 64'h0, 2'd0, 1'b0);
        step();
        chk("bp_ready2", 64'(in_ready), 64'd0);
        drive(4'b0100, 64'h208, 5'd3, 1'b1, 64'h0, 64'h33, 64'h0, 2'd0, 1'b0);
        step();
        chk("bp_stall_data", cmt_wdata, 64'h11);
        cmt_ready = 1'b1;
        #1;
        chk("full_pop_ready", 64'(in_ready), 64'd0);
        chk("full_pop_wen", 64'(rf_wen), 64'd1);
        step();
        chk("order_b", cmt_wdata, 64'h22);
        chk("order_b_rd", 64'(cmt_rd), 64'd2);
        chk("ready_rise", 64'(in_ready), 64'd1);
        step();
        chk("order_c", cmt_wdata, 64'h33);
        chk("order_c_pc", cmt_pc, 64'h208);
        in_valid = 1'b0;
        step();
        chk("no_dup", 64'(cmt_valid), 64'd0);

        cmt_ready = 1'b0;
        drive(4'b0100, 64'h300, 5'd7, 1'b1, 64'h0, 64'h77, 64'h0, 2'd0, 1'b0);
        step();
        step();
        in_valid = 1'b0;
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        cmt_ready = 1'b1;
        #1;
        chk("rstcyc_wen", 64'(rf_wen), 64'd0);
        chk("rstcyc_valid", 64'(cmt_valid), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(cmt_valid), 64'd0);
        chk("rst_mid_wen", 64'(rf_wen), 64'd0);
        chk("rst_mid_instret", 64'(instret), 64'd0);

        for (int i = 0; i < 17; i++) begin
            drive(4'b0100, 64'(i * 4), 5'd0, 1'b0, 64'h0, 64'(i), 64'h0, 2'd0, 1'b0);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("instret_wrap", 64'(instret), 64'(exp_cnt));
        chk("final_empty", 64'(cmt_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
